// File: rtl/branch_predictor_table.sv
// branch_predictor_table: table of saturating branch-direction counters.
// Lookups return the MSB of the indexed counter one cycle later.
// Resolved branches move their counter up or down.
// After reset the table is swept to INIT_CNT, one entry per cycle, before
// it accepts any lookup or update.
// Optional feature: define BP_GSHARE_EN for gshare indexing. In that mode a
// global history register is XORed into the PC index bits. Without the macro
// the table is purely bimodal and has no history register.
module branch_predictor_table #(
    parameter int ENTRIES  = 64,
    parameter int CNT_W    = 2,
    parameter int HIST_W   = 6,
    parameter int INIT_CNT = 2**CNT_W - 1,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lookup_valid_i,
    input  logic [31:0]      lookup_pc_i,
    output logic             predict_valid_o,
    output logic             predict_o,
    output logic [IDX_W-1:0] predict_idx_o,
    input  logic             update_i,
    input  logic [IDX_W-1:0] update_idx_i,
    input  logic             update_taken_i,
    output logic             ready_o
);

    localparam logic [CNT_W-1:0] CNT_INIT_VAL = CNT_W'(INIT_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] SWEEP_LAST   = IDX_W'(ENTRIES - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] sweep_idx_q;
    logic [CNT_W-1:0] cnt_mem [ENTRIES];

    logic             run;
    logic             lookup_fire;
    logic             update_fire;
    logic [IDX_W-1:0] lookup_idx;
    logic [CNT_W-1:0] lookup_cnt;
    logic [CNT_W-1:0] update_cnt;

    logic             pred_vld_p1;
    logic             pred_taken_p1;
    logic [IDX_W-1:0] pred_idx_p1;

    // Only the word-aligned PC bits that form the index are used.
    logic unused_pc;
    assign unused_pc = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0]};

    // Move a counter one step towards the resolved outcome.
    // The counter holds at 0 and at CNT_MAX.
    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cnt,
                                                  input logic             taken);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != CNT_MAX) res = cnt + CNT_W'(1);
        end else begin
            if (cnt != '0) res = cnt - CNT_W'(1);
        end
        return res;
    endfunction

    assign run         = (state_q == ST_RUN);
    assign lookup_fire = lookup_valid_i & run & ~rst_i;
    assign update_fire = update_i & run & ~rst_i;

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] ghr_q;

    // Non-speculative global history: only resolved outcomes are shifted in.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ghr_q <= '0;
        end else if (update_fire) begin
            ghr_q <= (ghr_q << 1) | HIST_W'(update_taken_i);
        end
    end

    // The history register is zero-extended and folded into the PC index.
    always_comb begin
        lookup_idx = lookup_pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
    end
`else
    localparam int unused_hist_w = HIST_W;

    // The bimodal index is taken straight from the PC.
    always_comb begin
        lookup_idx = lookup_pc_i[IDX_W+1:2];
    end
`endif

    assign lookup_cnt = cnt_mem[lookup_idx];
    assign update_cnt = sat_step(cnt_mem[update_idx_i], update_taken_i);

    // State register: reset always returns to the start of the sweep.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave INIT right after the last entry is written.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (sweep_idx_q == SWEEP_LAST) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Output decode: the table accepts traffic only once the sweep is done.
    always_comb begin
        ready_o = 1'b0;
        if (state_q == ST_RUN) ready_o = 1'b1;
    end

    // Sweep pointer: advances once per INIT cycle, so the sweep takes ENTRIES cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sweep_idx_q <= '0;
        end else if (state_q == ST_INIT) begin
            sweep_idx_q <= sweep_idx_q + IDX_W'(1);
        end
    end

    // Counter storage: written by the init sweep or by resolved updates.
    // The counters have no reset; they are initialised by the sweep instead.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == ST_INIT) begin
            cnt_mem[sweep_idx_q] <= CNT_INIT_VAL;
        end else if (update_fire) begin
            cnt_mem[update_idx_i] <= update_cnt;
        end
    end

    // Prediction register, stage 1.
    // It samples the pre-update counter, so a same-cycle update is not visible
    // to the lookup (read-before-write).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pred_vld_p1   <= 1'b0;
            pred_taken_p1 <= 1'b0;
            pred_idx_p1   <= '0;
        end else begin
            pred_vld_p1 <= lookup_fire;
            if (lookup_fire) begin
                pred_taken_p1 <= lookup_cnt[CNT_W-1];
                pred_idx_p1   <= lookup_idx;
            end
        end
    end

    assign predict_valid_o = pred_vld_p1;
    assign predict_o       = pred_taken_p1;
    assign predict_idx_o   = pred_idx_p1;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Testbench for branch_predictor_table.
// The stimulus pushes expected predictions into a queue. A monitor pops and
// compares them whenever the DUT presents a valid prediction.
`timescale 1ns/1ps
module tb_branch_predictor_table;

    localparam int IDX_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             lookup_valid;
    logic [31:0]      lookup_pc;
    logic             predict_valid;
    logic             predict;
    logic [IDX_W-1:0] predict_idx;
    logic             update;
    logic [IDX_W-1:0] update_idx;
    logic             update_taken;
    logic             ready;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } exp_t;

    exp_t             exp_q[$];
    logic [IDX_W-1:0] ghr_m = '0;
    logic             run_m = 1'b0;

    always #5 clk = ~clk;

    branch_predictor_table dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .lookup_valid_i  (lookup_valid),
        .lookup_pc_i     (lookup_pc),
        .predict_valid_o (predict_valid),
        .predict_o       (predict),
        .predict_idx_o   (predict_idx),
        .update_i        (update),
        .update_idx_i    (update_idx),
        .update_taken_i  (update_taken),
        .ready_o         (ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Build a PC whose lookup lands on table entry t under the current history.
    function automatic logic [31:0] pc_for(input logic [IDX_W-1:0] t);
`ifdef BP_GSHARE_EN
        return {24'd0, t ^ ghr_m, 2'b00};
`else
        return {24'd0, t, 2'b00};
`endif
    endfunction

    // Drive one cycle of stimulus and queue the expected prediction.
    task automatic cycle(input logic lv, input logic [31:0] pc, input logic up,
                         input logic [IDX_W-1:0] uidx, input logic utk,
                         input logic [IDX_W-1:0] eidx, input logic etk);
        lookup_valid = lv;
        lookup_pc    = pc;
        update       = up;
        update_idx   = uidx;
        update_taken = utk;
        if (lv && run_m) exp_q.push_back({eidx, etk});
        @(negedge clk);
        lookup_valid = 1'b0;
        update       = 1'b0;
        if (up && run_m) ghr_m = {ghr_m[IDX_W-2:0], utk};
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [IDX_W-1:0] eidx, input logic etk);
        cycle(1'b1, pc, 1'b0, '0, 1'b0, eidx, etk);
        cycle(1'b0, 32'd0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic upd(input logic [IDX_W-1:0] idx, input logic tk);
        cycle(1'b0, 32'd0, 1'b1, idx, tk, '0, 1'b0);
    endtask

    // Count cycles after reset release and check when ready_o rises.
    // Optionally inject INIT-time traffic, which must be ignored.
    task automatic wait_ready(input logic inject);
        for (int k = 1; k <= 64; k++) begin
            update       = inject && (k == 40 || k == 41);
            update_idx   = 6'd3;
            update_taken = 1'b0;
            lookup_valid = inject && (k == 45);
            lookup_pc    = 32'h0000_000C;
            @(negedge clk);
            update       = 1'b0;
            lookup_valid = 1'b0;
            check($sformatf("ready_cycle_%0d", k), 32'(ready), 32'(k == 64));
        end
        run_m = 1'b1;
        ghr_m = '0;
    endtask

    // Scoreboard monitor: compares each valid prediction and checks the hold behaviour.
    initial begin : monitor
        logic             hold;
        logic             last_t;
        logic [IDX_W-1:0] last_i;
        exp_t             e;
        hold = 1'b0;
        last_t = 1'b0;
        last_i = '0;
        forever begin
            @(negedge clk);
            if (predict_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_predict_valid", 32'(predict_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("predict_idx", 32'(predict_idx), 32'(e.idx));
                    check("predict_taken", 32'(predict), 32'(e.taken));
                end
                last_t = predict;
                last_i = predict_idx;
                hold   = 1'b1;
            end else if (hold) begin
                check("hold_predict", 32'(predict), 32'(last_t));
                check("hold_predict_idx", 32'(predict_idx), 32'(last_i));
                hold = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst = 1'b1;
        lookup_valid = 1'b0;
        lookup_pc = '0;
        update = 1'b0;
        update_idx = '0;
        update_taken = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_predict_valid", 32'(predict_valid), 32'd0);
        check("reset_predict", 32'(predict), 32'd0);
        check("reset_predict_idx", 32'(predict_idx), 32'd0);
        rst = 1'b0;
        wait_ready(1'b0);

        // Freshly initialised entries predict taken.
        lookup(32'h0000_0040, 6'd16, 1'b1);

        // Saturation on entry 5.
        repeat (4) upd(6'd5, 1'b0);
        lookup(pc_for(6'd5), 6'd5, 1'b0);
        upd(6'd5, 1'b1);
        lookup(pc_for(6'd5), 6'd5, 1'b0);
        upd(6'd5, 1'b1);
        lookup(pc_for(6'd5), 6'd5, 1'b1);
        repeat (3) upd(6'd5, 1'b1);
        upd(6'd5, 1'b0);
        lookup(pc_for(6'd5), 6'd5, 1'b1);

        // Same-cycle lookup and update on entry 5 (counter 2): read-before-write.
        cycle(1'b1, pc_for(6'd5), 1'b1, 6'd5, 1'b0, 6'd5, 1'b1);
        lookup(pc_for(6'd5), 6'd5, 1'b0);
        repeat (2) @(negedge clk);

        // Reset from RUN, then again mid-sweep; INIT-time traffic is ignored.
        run_m = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rerun_reset_ready", 32'(ready), 32'd0);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready(1'b1);

        // History T,T,N, then lookup of pc 0x100.
        upd(6'd9, 1'b1);
        upd(6'd9, 1'b1);
        upd(6'd9, 1'b0);
`ifdef BP_GSHARE_EN
        lookup(32'h0000_0100, 6'h06, 1'b1);
`else
        lookup(32'h0000_0100, 6'h00, 1'b1);
`endif
        // Entry 3 was targeted by not-taken updates during INIT; it must still be 3.
        lookup(pc_for(6'd3), 6'd3, 1'b1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
